seq_det_prog: RTL and testbench
===============================

Name: seq_det_prog

Overview:
Programmable serial bit-pattern detector. It is the parametrised successor to the fixed-pattern Moore detector. It scans a qualified serial bit stream for a run-time-loaded pattern of 1..PAT_W bits. It supports overlapping and non-overlapping detection, a match pulse, and a saturating match counter. It sits after the serial receive/deserialiser front-end and feeds the control/status block.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of the match counter (1..32)
LEN_W, clog2(PAT_W+1), localparam, width of the length field; not overridable

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
cfg_load  input  1  one-cycle strobe; captures cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  PAT_W  pattern; bit [cfg_len-1] is received first, bit [0] is received last
cfg_len  input  LEN_W  pattern length; valid range 1..PAT_W
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
enable  input  1  detection enable; when 0, bits are ignored and the history is held
in_valid  input  1  qualifies in_bit
in_bit  input  1  serial data bit
clr_count  input  1  synchronous clear of match_count and count_sat
match  output  1  registered one-cycle pulse per detected occurrence
match_count  output  CNT_W  number of matches; saturating
count_sat  output  1  sticky; set when match_count reaches all-ones
cfg_err  output  1  1 while the loaded cfg_len is 0 or greater than PAT_W
armed  output  1  1 when the configuration is valid, enable=1 and bits_seen >= len

Behaviour:
- Reset: match=0, match_count=0, count_sat=0, cfg_err=1, armed=0.
  - Internal state on reset: pattern=0, len=0, overlap=0, history=0, bits_seen=0.
  - The block is inert until the first cfg_load.
- Internal state:
  - history: PAT_W-bit shift register.
  - bits_seen: saturates at PAT_W.
  - pat_reg, len_reg, ovl_reg: configuration registers.
- Config load (cfg_load=1):
  - Capture pat_reg, len_reg and ovl_reg.
  - Clear history and bits_seen.
  - cfg_err = (cfg_len==0 || cfg_len>PAT_W), registered in the same edge.
  - match is 0 in the following cycle.
  - cfg_load has priority over a coincident in_valid; that bit is dropped.
  - match_count is not affected.
- Bit accept, when enable=1, in_valid=1, cfg_load=0:
  - history <= {history[PAT_W-2:0], in_bit}.
  - bits_seen <= min(bits_seen+1, PAT_W).
- Match condition, evaluated on the post-shift value:
  - cfg_err=0, AND
  - new bits_seen >= len_reg, AND
  - new history[len_reg-1:0] == pat_reg[len_reg-1:0] (bits above len_reg are masked).
- Latency: match is registered and asserts in the cycle after the clock edge that accepts the completing bit. Exactly one pulse per occurrence.
- Overlap mode (ovl_reg=1): history and bits_seen continue unchanged after a match.
- Non-overlap mode (ovl_reg=0): on a match, bits_seen <= 0. History may keep its contents but is masked by bits_seen. The next match needs len_reg fresh bits.
- Bits with in_valid=0 or enable=0:
  - No shift and no match.
  - State is held; gaps are transparent.
- Deasserting enable does not clear history.
- Counter:
  - On a match, match_count <= match_count+1 unless it is already all-ones.
  - count_sat is set when the count reaches all-ones and stays set until clr_count or rst.
  - If clr_count and a match occur in the same cycle, clear wins: count=0, count_sat=0. The match pulse is still issued.
- Length 1: every accepted bit equal to pat_reg[0] matches, in both modes.
- Reset mid-stream: all outputs and state return to their reset values immediately (asynchronous). The configuration must be reloaded.

Test Plan:
- Overlap: load pat=4'b1101, len=4, overlap=1; stream 1,1,0,1,1,0,1 -> match pulses the cycle after bit 4 and after bit 7; match_count=2.
- Non-overlap: same configuration with overlap=0 and the same stream -> a single pulse after bit 4; match_count=1.
- Gaps and enable: pat=3'b101, len=3; send 1,(in_valid=0 x3),0,(enable=0 with in_valid=1, bit=0),1 -> one match after the final bit; the gated bit is ignored.
- Saturation and clear: CNT_W=2, pat=1, len=1, stream of five 1s -> count 1,2,3,3,3; count_sat=1 after the third match. Then clr_count coincident with a sixth match -> match pulse issued, count=0, count_sat=0.
- Config error: cfg_len=0, then cfg_len=PAT_W+1 (LEN_W allowing) -> cfg_err=1, no match on any stream. Reload len=2, pat=2'b11 -> cfg_err=0; bits 1,1 -> match.
- Reset and reload mid-stream: assert rst after 3 of 4 pattern bits -> outputs reset, no match on the 4th bit. Also cfg_load coincident with an in_valid bit -> that bit is dropped and bits_seen=0.

Source files
------------

// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - programmable serial bit-pattern detector with saturating match counter
//
// Scans a qualified serial bit stream for a run-time-loaded pattern of
// 1..PAT_W bits. Detection can be overlapping or non-overlapping.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   cfg_load     one-cycle strobe capturing cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  pattern; bit [cfg_len-1] is received first, bit [0] last
//   cfg_len      pattern length, valid 1..PAT_W
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   enable       detection enable; when 0, bits are ignored and state held
//   in_valid     qualifies in_bit
//   in_bit       serial data bit
//   clr_count    synchronous clear of match_count and count_sat
//   match        registered one-cycle pulse per detected occurrence
//   match_count  saturating match counter
//   count_sat    sticky flag, set when match_count reaches all-ones
//   cfg_err      1 while the loaded length is 0 or greater than PAT_W
//   armed        configuration valid, enable=1 and enough bits collected

module seq_det_prog #(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 8,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             enable,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic             cfg_err,
    output logic             armed
);

    localparam logic [LEN_W-1:0] SEEN_MAX = LEN_W'(PAT_W);
    localparam logic [PAT_W:0]   ONE_EXT  = (PAT_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_MAX - CNT_W'(1);

    logic [PAT_W-1:0] pat_reg;
    logic [LEN_W-1:0] len_reg;
    logic             ovl_reg;
    logic [PAT_W-1:0] history;
    logic [LEN_W-1:0] bits_seen;

    logic             accept;
    logic [PAT_W-1:0] new_hist;
    logic [LEN_W-1:0] new_seen;
    logic [PAT_W-1:0] len_mask;
    logic             hit;

    always_comb begin
        accept   = enable && in_valid && !cfg_load;
        new_hist = {history[PAT_W-2:0], in_bit};
        new_seen = (bits_seen == SEEN_MAX) ? bits_seen : bits_seen + LEN_W'(1);
        // Low len_reg bits set; len_reg == PAT_W yields all ones because the
        // shift is done one bit wider than the pattern.
        len_mask = PAT_W'((ONE_EXT << len_reg) - ONE_EXT);
        hit      = accept && !cfg_err && (new_seen >= len_reg) &&
                   (((new_hist ^ pat_reg) & len_mask) == '0);
    end

    assign armed = !cfg_err && enable && (bits_seen >= len_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg     <= '0;
            len_reg     <= '0;
            ovl_reg     <= 1'b0;
            history     <= '0;
            bits_seen   <= '0;
            cfg_err     <= 1'b1;
            match       <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            match <= hit;

            if (cfg_load) begin
                pat_reg   <= cfg_pattern;
                len_reg   <= cfg_len;
                ovl_reg   <= cfg_overlap;
                history   <= '0;
                bits_seen <= '0;
                cfg_err   <= (cfg_len == '0) || (cfg_len > SEEN_MAX);
            end else if (accept) begin
                history <= new_hist;
                // Non-overlapping: stale history is masked by bits_seen, so
                // the next occurrence needs len_reg fresh bits.
                bits_seen <= (hit && !ovl_reg) ? '0 : new_seen;
            end

            if (clr_count) begin
                match_count <= '0;
                count_sat   <= 1'b0;
            end else if (hit && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
                if (match_count == CNT_PRE) begin
                    count_sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// tb/tb_seq_det_prog.sv - self-checking bench for seq_det_prog

module tb_seq_det_prog;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             enable;
    logic             in_valid;
    logic             in_bit;
    logic             clr_count;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;
    logic             cfg_err;
    logic             armed;

    seq_det_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .clr_count   (clr_count),
        .match       (match),
        .match_count (match_count),
        .count_sat   (count_sat),
        .cfg_err     (cfg_err),
        .armed       (armed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the list of accepted bits since the last load (or since
    // the last match in non-overlap mode), oldest first.
    bit [PAT_W-1:0] m_pat;
    int             m_len;
    bit             m_ovl;
    bit             m_err;
    bit             q[$];
    int             m_cnt;
    bit             m_sat;
    bit             m_match;

    function automatic bit tail_matches();
        int base;
        if (q.size() < m_len) return 1'b0;
        base = q.size() - m_len;
        for (int i = 0; i < m_len; i++)
            if (q[base + i] != m_pat[m_len - 1 - i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_pat = '0; m_len = 0; m_ovl = 0; m_err = 1;
        q = {}; m_cnt = 0; m_sat = 0; m_match = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".match"}, 32'(match), 32'(m_match));
        chk({tag, ".count"}, 32'(match_count), 32'(m_cnt));
        chk({tag, ".sat"}, 32'(count_sat), 32'(m_sat));
        chk({tag, ".err"}, 32'(cfg_err), 32'(m_err));
        chk({tag, ".armed"}, 32'(armed),
            32'(!m_err && enable && (q.size() >= m_len)));
    endtask

    // One clock: drive inputs, advance the model, clock, compare.
    task automatic step(input bit ld, input bit [PAT_W-1:0] pat, input int len,
                        input bit ovl, input bit en, input bit v, input bit b,
                        input bit clr, input string tag);
        cfg_load = ld; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
        enable = en; in_valid = v; in_bit = b; clr_count = clr;
        m_match = 0;
        if (ld) begin
            m_pat = pat; m_len = len; m_ovl = ovl;
            m_err = (len == 0) || (len > PAT_W);
            q = {};
        end else if (en && v) begin
            q.push_back(b);
            if (q.size() > PAT_W) void'(q.pop_front());
            if (!m_err && tail_matches()) begin
                m_match = 1;
                if (!m_ovl) q = {};
            end
        end
        if (clr) begin
            m_cnt = 0; m_sat = 0;
        end else if (m_match && m_cnt < CMAX) begin
            m_cnt++;
            if (m_cnt == CMAX) m_sat = 1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input bit [PAT_W-1:0] pat, input int len, input bit ovl);
        step(1, pat, len, ovl, 1, 0, 0, 0, "load");
    endtask

    task automatic send(input bit b);
        step(0, '0, 0, 0, 1, 1, b, 0, "bit");
    endtask

    task automatic idle(input bit en, input bit v, input bit b);
        step(0, '0, 0, 0, en, v, b, 0, "gap");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all("rst");
        rst = 1'b0;
    endtask

    initial begin
        bit [6:0] s_ovl;
        rst = 1'b0; cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
        enable = 0; in_valid = 0; in_bit = 0; clr_count = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        idle(1, 1, 1);
        chk("inert_match", 32'(match), 0);

        // Overlap: 1101 over 1,1,0,1,1,0,1 -> two matches
        s_ovl = 7'b1101101;
        step(0, '0, 0, 0, 1, 0, 0, 1, "clr");
        load(8'b1101, 4, 1);
        for (int i = 6; i >= 0; i--) send(s_ovl[i]);
        chk("ovl_count", 32'(match_count), 2);

        // Non-overlap: same stream -> one match
        step(0, '0, 0, 0, 1, 0, 0, 1, "clr");
        load(8'b1101, 4, 0);
        for (int i = 6; i >= 0; i--) send(s_ovl[i]);
        chk("novl_count", 32'(match_count), 1);

        // Gaps and enable gating
        step(0, '0, 0, 0, 1, 0, 0, 1, "clr");
        load(8'b101, 3, 1);
        send(1);
        repeat (3) idle(1, 0, 1);
        send(0);
        idle(0, 1, 0);
        send(1);
        chk("gap_match", 32'(match), 1);

        // Saturation and clear-wins
        step(0, '0, 0, 0, 1, 0, 0, 1, "clr");
        load(8'b1, 1, 0);
        for (int i = 0; i < 5; i++) send(1);
        chk("sat_count", 32'(match_count), 3);
        chk("sat_flag", 32'(count_sat), 1);
        step(0, '0, 0, 0, 1, 1, 1, 1, "clr_hit");
        chk("clr_hit_match", 32'(match), 1);
        chk("clr_hit_count", 32'(match_count), 0);

        // Config errors then recovery
        load(8'b11, 0, 1);
        send(1); send(1);
        load(8'b11, PAT_W + 1, 1);
        for (int i = 0; i < 10; i++) send(1);
        chk("err_len9", 32'(cfg_err), 1);
        load(8'b11, 2, 1);
        chk("err_clear", 32'(cfg_err), 0);
        send(1); send(1);
        chk("len2_match", 32'(match), 1);

        // Reset after 3 of 4 bits
        load(8'b1101, 4, 1);
        send(1); send(1); send(0);
        do_reset();
        send(1);
        chk("rst_nomatch", 32'(match), 0);

        // Load coincident with a valid bit drops the bit
        load(8'b1, 1, 1);
        step(1, 8'b1, 1, 1, 1, 1, 1, 0, "ld_bit");
        chk("ld_drop_armed", 32'(armed), 0);
        chk("ld_drop_match", 32'(match), 0);

        // Randomized traffic with short patterns to make matches frequent
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset();
            end else if (r < 25) begin
                int len;
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, PAT_W + 1)
                                                  : $urandom_range(1, 4);
                step(1, PAT_W'($urandom), len, 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 0, "rnd_ld");
            end else begin
                step(0, '0, 0, 0, $urandom_range(0, 9) != 0,
                     $urandom_range(0, 3) != 0, 1'($urandom),
                     $urandom_range(0, 39) == 0, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
